// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-ported, byte-addressed data memory between instruction
//   fetch (IF) and load/store (LS). Each transaction is accepted in IDLE,
//   holds the memory controls for MEM_LAT cycles in ACCESS, and returns a
//   registered response for one cycle in RESP. LS has priority. After
//   STARVE_MAX consecutive IF losses, IF wins the next arbitration.
//   Misaligned or illegal LS requests skip ACCESS and answer with ls_err.
// Ports
//   clk, rst_n                      clock, synchronous active-low reset
//   if_req/if_addr -> if_gnt        IF read request and combinational accept
//   if_valid/if_rdata               IF response (one-cycle pulse)
//   ls_req/we/size/signed/addr/wdata -> ls_gnt   LS request and accept
//   ls_valid/ls_err/ls_rdata        LS response (one-cycle pulse)
//   mem_read/write/size/signed/addr/wdata, mem_rdata   memory side
//   busy                            high whenever not IDLE
module mem_port_arbiter #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [1:0]        ls_size,
    input  logic              ls_signed,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_gnt,
    output logic              ls_valid,
    output logic              ls_err,
    output logic [DATA_W-1:0] ls_rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [1:0]        mem_size,
    output logic              mem_signed,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam int SC_W  = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_e;

    state_e              state_q, state_d;
    logic [SC_W-1:0]     starve_q;
    logic [LAT_W-1:0]    lat_q;
    logic                owner_ls_q;   // 1 = LS owns the transaction
    logic                we_q, signed_q, err_q;
    logic [1:0]          size_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q, rdata_q;

    logic starve_full, ls_win, misalign, lat_last;

    assign starve_full = (starve_q == SC_W'(STARVE_MAX));
    // IF only beats a pending LS once it has been starved long enough.
    assign ls_win      = ls_req && !(if_req && starve_full);
    assign misalign    = (ls_size == 2'b11) ||
                         (ls_size == 2'b00 && ls_addr[1:0] != 2'b00) ||
                         (ls_size == 2'b01 && ls_addr[0]);
    assign lat_last    = (lat_q == LAT_W'(MEM_LAT - 1));

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (ls_gnt)      state_d = misalign ? S_RESP : S_ACCESS;
                else if (if_gnt) state_d = S_ACCESS;
            end
            S_ACCESS: if (lat_last) state_d = S_RESP;
            S_RESP:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy       = (state_q != S_IDLE);
        // Grants are held off while reset is asserted so nothing looks accepted.
        ls_gnt     = rst_n && (state_q == S_IDLE) && ls_win;
        if_gnt     = rst_n && (state_q == S_IDLE) && !ls_win && if_req;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_size   = 2'b00;
        mem_signed = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        if_valid   = 1'b0;
        if_rdata   = '0;
        ls_valid   = 1'b0;
        ls_err     = 1'b0;
        ls_rdata   = '0;
        if (state_q == S_ACCESS) begin
            mem_read   = !we_q;
            // A store is a single write strobe, not one per latency cycle.
            mem_write  = we_q && (lat_q == '0);
            mem_size   = size_q;
            mem_signed = signed_q;
            mem_addr   = addr_q;
            mem_wdata  = wdata_q;
        end
        if (state_q == S_RESP) begin
            if (owner_ls_q) begin
                ls_valid = 1'b1;
                ls_err   = err_q;
                ls_rdata = rdata_q;
            end else begin
                if_valid = 1'b1;
                if_rdata = rdata_q;
            end
        end
    end

    // Request latch, latency counter, starvation counter, response register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            starve_q   <= '0;
            lat_q      <= '0;
            owner_ls_q <= 1'b0;
            we_q       <= 1'b0;
            signed_q   <= 1'b0;
            err_q      <= 1'b0;
            size_q     <= 2'b00;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
        end else begin
            if (state_q == S_IDLE) begin
                if (if_gnt || !if_req)           starve_q <= '0;
                else if (ls_gnt && !starve_full) starve_q <= starve_q + SC_W'(1);
            end

            if (ls_gnt) begin
                owner_ls_q <= 1'b1;
                we_q       <= ls_we;
                size_q     <= ls_size;
                signed_q   <= ls_signed;
                addr_q     <= ls_addr;
                wdata_q    <= ls_wdata;
                err_q      <= misalign;
                rdata_q    <= '0;
            end else if (if_gnt) begin
                owner_ls_q <= 1'b0;
                we_q       <= 1'b0;
                size_q     <= 2'b00;
                signed_q   <= 1'b0;
                addr_q     <= if_addr;
                wdata_q    <= '0;
                err_q      <= 1'b0;
                rdata_q    <= '0;
            end

            if (state_q == S_ACCESS && !lat_last) lat_q <= lat_q + LAT_W'(1);
            else                                  lat_q <= '0;

            // Stores keep the zero response loaded at grant.
            if (state_q == S_ACCESS && lat_last && !we_q) rdata_q <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
    localparam int AW  = 8;
    localparam int DW  = 32;
    localparam int LAT = 3;
    localparam int SM  = 4;

    logic          clk = 1'b0, rst_n = 1'b0;
    logic          if_req = 1'b0, if_gnt, if_valid;
    logic [AW-1:0] if_addr = '0;
    logic [DW-1:0] if_rdata;
    logic          ls_req = 1'b0, ls_we = 1'b0, ls_signed = 1'b0, ls_gnt, ls_valid, ls_err;
    logic [1:0]    ls_size = 2'b00;
    logic [AW-1:0] ls_addr = '0;
    logic [DW-1:0] ls_wdata = '0, ls_rdata;
    logic          mem_read, mem_write, mem_signed, busy;
    logic [1:0]    mem_size;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    int n_chk = 0, n_err = 0;
    int m_starve = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT), .STARVE_MAX(SM)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_valid(if_valid), .if_rdata(if_rdata),
        .ls_req(ls_req), .ls_we(ls_we), .ls_size(ls_size), .ls_signed(ls_signed), .ls_addr(ls_addr),
        .ls_wdata(ls_wdata), .ls_gnt(ls_gnt), .ls_valid(ls_valid), .ls_err(ls_err), .ls_rdata(ls_rdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_size(mem_size), .mem_signed(mem_signed),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    // ---------------- memory device and reference contents ----------------
    logic [7:0] dev_mem [256];
    logic [7:0] ref_mem [256];
    logic       pl_en = 1'b0;
    logic [7:0] pl_addr = '0, pl_data = '0;

    function automatic logic [31:0] ext(input logic [31:0] raw, input logic [1:0] sz, input logic sg);
        case (sz)
            2'b00:   return raw;
            2'b01:   return sg ? {{16{raw[15]}}, raw[15:0]} : {16'h0, raw[15:0]};
            default: return sg ? {{24{raw[7]}}, raw[7:0]} : {24'h0, raw[7:0]};
        endcase
    endfunction

    always @(posedge clk) begin
        if (pl_en) dev_mem[pl_addr] <= pl_data;
        else if (mem_write) begin
            dev_mem[mem_addr] <= mem_wdata[7:0];
            if (mem_size != 2'b10) dev_mem[8'(mem_addr + 8'd1)] <= mem_wdata[15:8];
            if (mem_size == 2'b00) begin
                dev_mem[8'(mem_addr + 8'd2)] <= mem_wdata[23:16];
                dev_mem[8'(mem_addr + 8'd3)] <= mem_wdata[31:24];
            end
        end
    end

    always_comb begin
        mem_rdata = 32'hA5A5_A5A5;
        if (mem_read)
            mem_rdata = ext({dev_mem[8'(mem_addr + 8'd3)], dev_mem[8'(mem_addr + 8'd2)],
                             dev_mem[8'(mem_addr + 8'd1)], dev_mem[mem_addr]}, mem_size, mem_signed);
    end

    function automatic logic [31:0] ref_ld(input logic [7:0] a, input logic [1:0] sz, input logic sg);
        return ext({ref_mem[8'(a + 8'd3)], ref_mem[8'(a + 8'd2)], ref_mem[8'(a + 8'd1)], ref_mem[a]}, sz, sg);
    endfunction

    task automatic ref_store(input logic [7:0] a, input logic [1:0] sz, input logic [31:0] d);
        ref_mem[a] = d[7:0];
        if (sz != 2'b10) ref_mem[8'(a + 8'd1)] = d[15:8];
        if (sz == 2'b00) begin
            ref_mem[8'(a + 8'd2)] = d[23:16];
            ref_mem[8'(a + 8'd3)] = d[31:24];
        end
    endtask

    function automatic logic mis(input logic [1:0] sz, input logic [7:0] a);
        return (sz == 2'b11) || (sz == 2'b00 && a[1:0] != 2'b00) || (sz == 2'b01 && a[0]);
    endfunction

    task automatic preload(input logic [7:0] a, input logic [7:0] d);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(posedge clk); #1;
        pl_en = 1'b0;
        ref_mem[a] = d;
    endtask

    task automatic set_ls(input logic we, input logic [1:0] sz, input logic sg, input logic [7:0] a, input logic [31:0] wd);
        ls_req = 1'b1; ls_we = we; ls_size = sz; ls_signed = sg; ls_addr = a; ls_wdata = wd;
    endtask

    // ---------------- transaction monitor (records, does not judge) ----------------
    typedef struct {
        logic g_if, g_ls, idle_busy, busy_low, busy_gnt, v_if, v_ls, err, resp_nz, msigned;
        int   vcyc, n_read, n_write, first_wr;
        logic [1:0]  msize;
        logic [7:0]  maddr;
        logic [31:0] mwdata, rdata;
    } obs_t;

    // Called between the active edge and the falling edge of an IDLE cycle with requests applied.
    task automatic run_txn(input bit hold, output obs_t o);
        o = '{default: '0};
        @(negedge clk);
        o.g_if = if_gnt; o.g_ls = ls_gnt; o.idle_busy = busy;
        if (!(o.g_if || o.g_ls)) return;
        @(posedge clk); #1;
        if (!hold) begin
            if (o.g_ls) ls_req = 1'b0;
            else        if_req = 1'b0;
        end
        for (int c = 1; c <= LAT + 3; c++) begin
            @(negedge clk);
            if (!busy) o.busy_low = 1'b1;
            if (if_gnt || ls_gnt) o.busy_gnt = 1'b1;
            if (mem_write) begin
                o.n_write++;
                if (o.first_wr == 0) o.first_wr = c;
                o.mwdata = mem_wdata;
            end
            if (mem_read) o.n_read++;
            if (mem_read || mem_write) begin
                o.maddr = mem_addr; o.msize = mem_size; o.msigned = mem_signed;
            end
            if (if_valid || ls_valid) begin
                o.vcyc = c; o.v_if = if_valid; o.v_ls = ls_valid; o.err = ls_err;
                o.rdata = if_valid ? if_rdata : ls_rdata;
                o.resp_nz = |{mem_read, mem_write, mem_size, mem_signed, mem_addr, mem_wdata};
                break;
            end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [2*DW+3*AW+16:0] outs;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        outs = {if_gnt, if_valid, if_rdata, ls_gnt, ls_valid, ls_err, ls_rdata, mem_read, mem_write,
                mem_size, mem_signed, mem_addr, mem_wdata[AW-1:0], busy};
        n_chk++; if (outs !== '0 || mem_wdata !== '0) begin n_err++; $display("FAIL reset_outputs got=%0h exp=0", outs); end
        @(posedge clk); #1;
        rst_n = 1'b1; m_starve = 0;
        @(negedge clk);
        n_chk++; if ({busy, if_gnt, ls_gnt} !== 3'b000) begin n_err++; $display("FAIL reset_idle got=%b exp=000", {busy, if_gnt, ls_gnt}); end
    endtask

    task automatic test_if_fetch();
        obs_t o;
        preload(8'h04, 8'h09); preload(8'h05, 8'h00); preload(8'h06, 8'h00); preload(8'h07, 8'h00);
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = 8'h04;
        run_txn(1'b0, o);
        m_starve = 0;
        n_chk++; if ({o.g_if, o.g_ls} !== 2'b10) begin n_err++; $display("FAIL if_grant got=%b exp=10", {o.g_if, o.g_ls}); end
        n_chk++; if (o.n_read !== LAT || o.n_write !== 0) begin n_err++; $display("FAIL if_mem_read got=%0d/%0d exp=%0d/0", o.n_read, o.n_write, LAT); end
        n_chk++; if (o.vcyc !== LAT + 1 || {o.v_if, o.v_ls} !== 2'b10) begin n_err++; $display("FAIL if_latency got=%0d exp=%0d", o.vcyc, LAT + 1); end
        n_chk++; if (o.rdata !== 32'h0000_0009) begin n_err++; $display("FAIL if_rdata got=%h exp=00000009", o.rdata); end
        n_chk++; if ({o.maddr, o.msize, o.msigned} !== {8'h04, 2'b00, 1'b0}) begin n_err++; $display("FAIL if_mem_ctrl got=%h exp=%h", {o.maddr, o.msize, o.msigned}, {8'h04, 2'b00, 1'b0}); end
    endtask

    task automatic test_store_load();
        obs_t o;
        @(posedge clk); #1;
        set_ls(1'b1, 2'b00, 1'b0, 8'h08, 32'hDEAD_BEEF);
        run_txn(1'b0, o);
        ref_store(8'h08, 2'b00, 32'hDEAD_BEEF);
        n_chk++; if (o.n_write !== 1 || o.first_wr !== 1 || o.n_read !== 0) begin n_err++; $display("FAIL sw_strobe got=%0d@%0d rd=%0d exp=1@1 rd=0", o.n_write, o.first_wr, o.n_read); end
        n_chk++; if (o.mwdata !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL sw_wdata got=%h exp=deadbeef", o.mwdata); end
        n_chk++; if ({o.v_ls, o.err, o.rdata} !== {2'b10, 32'h0}) begin n_err++; $display("FAIL sw_resp got=%b/%b/%h exp=1/0/0", o.v_ls, o.err, o.rdata); end
        @(posedge clk); #1;
        set_ls(1'b0, 2'b00, 1'b0, 8'h08, 32'h0);
        run_txn(1'b0, o);
        n_chk++; if (o.rdata !== 32'hDEAD_BEEF || o.err !== 1'b0) begin n_err++; $display("FAIL lw_rdata got=%h err=%b exp=deadbeef err=0", o.rdata, o.err); end
        n_chk++; if (o.n_read !== LAT || o.n_write !== 0) begin n_err++; $display("FAIL lw_strobe got=%0d/%0d exp=%0d/0", o.n_read, o.n_write, LAT); end
    endtask

    task automatic test_lh_signed();
        obs_t o;
        preload(8'h02, 8'h01); preload(8'h03, 8'hF0);
        @(posedge clk); #1;
        set_ls(1'b0, 2'b01, 1'b1, 8'h02, 32'h0);
        run_txn(1'b0, o);
        n_chk++; if ({o.msize, o.msigned} !== 3'b011) begin n_err++; $display("FAIL lh_ctrl got=%b exp=011", {o.msize, o.msigned}); end
        n_chk++; if (o.rdata !== 32'hFFFF_F001) begin n_err++; $display("FAIL lh_rdata got=%h exp=fffff001", o.rdata); end
    endtask

    task automatic test_misaligned();
        obs_t o;
        @(posedge clk); #1;
        set_ls(1'b1, 2'b00, 1'b0, 8'h06, 32'h1234_5678);
        run_txn(1'b0, o);
        n_chk++; if (o.n_read + o.n_write !== 0) begin n_err++; $display("FAIL mis_no_access got=%0d exp=0", o.n_read + o.n_write); end
        n_chk++; if ({o.vcyc, o.v_ls, o.err, o.rdata} !== {32'd1, 2'b11, 32'h0}) begin n_err++; $display("FAIL mis_resp got=cyc%0d v%b e%b %h exp=cyc1 v1 e1 0", o.vcyc, o.v_ls, o.err, o.rdata); end
        n_chk++; if (o.resp_nz !== 1'b0) begin n_err++; $display("FAIL mis_mem_idle got=%b exp=0", o.resp_nz); end
    endtask

    task automatic test_starvation();
        obs_t o;
        int lost = 0, max_lost = 0;
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = 8'h20;
        set_ls(1'b0, 2'b00, 1'b0, 8'h30, 32'h0);
        for (int i = 0; i < 10; i++) begin
            run_txn(1'b1, o);
            n_chk++; if (o.g_ls !== (i % 5 != 4) || o.g_if !== (i % 5 == 4)) begin n_err++; $display("FAIL starve_order[%0d] got=if%b ls%b exp=%s", i, o.g_if, o.g_ls, (i % 5 == 4) ? "IF" : "LS"); end
            if (o.g_ls) lost++; else lost = 0;
            if (lost > max_lost) max_lost = lost;
            @(posedge clk); #1;
        end
        if_req = 1'b0; ls_req = 1'b0; m_starve = 0;
        n_chk++; if (max_lost > SM) begin n_err++; $display("FAIL starve_bound got=%0d exp<=%0d", max_lost, SM); end
    endtask

    task automatic test_random();
        obs_t o;
        logic e_ls, e_err, e_st, a_ifreq, e_sg;
        logic [1:0] e_sz;
        logic [7:0] a_addr;
        logic [31:0] a_wd, e_rd;
        int e_nr, e_nw, r;
        for (int t = 0; t < 60; t++) begin
            @(posedge clk); #1;
            if (!if_req && $urandom_range(0, 1) == 1) begin
                if_req = 1'b1; if_addr = {6'($urandom_range(0, 63)), 2'b00};
            end
            if (!ls_req && ($urandom_range(0, 2) != 0 || !if_req)) begin
                r = $urandom_range(0, 9);
                ls_size = (r < 4) ? 2'b00 : (r < 7) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
                ls_addr = 8'($urandom_range(0, 255));
                if ($urandom_range(0, 3) != 0)
                    ls_addr = ls_addr & ((ls_size == 2'b00) ? 8'hFC : (ls_size == 2'b01) ? 8'hFE : 8'hFF);
                ls_we = 1'($urandom_range(0, 1)); ls_signed = 1'($urandom_range(0, 1));
                ls_wdata = $urandom; ls_req = 1'b1;
            end
            a_ifreq = if_req;
            e_ls = ls_req && !(if_req && m_starve == SM);
            e_err = e_ls && mis(ls_size, ls_addr);
            e_st  = e_ls && ls_we;
            a_addr = e_ls ? ls_addr : if_addr;
            e_sz   = e_ls ? ls_size : 2'b00;
            e_sg   = e_ls ? ls_signed : 1'b0;
            a_wd   = ls_wdata;
            e_rd   = (e_err || e_st) ? 32'h0 : ref_ld(a_addr, e_sz, e_sg);
            e_nr   = (!e_err && !e_st) ? LAT : 0;
            e_nw   = (!e_err && e_st) ? 1 : 0;
            run_txn(1'b0, o);
            n_chk++; if ({o.g_if, o.g_ls} !== {!e_ls, e_ls}) begin n_err++; $display("FAIL rnd_grant[%0d] got=%b exp=%b", t, {o.g_if, o.g_ls}, {!e_ls, e_ls}); end
            n_chk++; if (o.vcyc !== (e_err ? 1 : LAT + 1) || {o.v_if, o.v_ls, o.err} !== {!e_ls, e_ls, e_err}) begin n_err++; $display("FAIL rnd_resp[%0d] got=cyc%0d %b exp=cyc%0d %b", t, o.vcyc, {o.v_if, o.v_ls, o.err}, e_err ? 1 : LAT + 1, {!e_ls, e_ls, e_err}); end
            n_chk++; if (o.rdata !== e_rd) begin n_err++; $display("FAIL rnd_rdata[%0d] got=%h exp=%h", t, o.rdata, e_rd); end
            n_chk++; if (o.n_read !== e_nr || o.n_write !== e_nw) begin n_err++; $display("FAIL rnd_strobes[%0d] got=%0d/%0d exp=%0d/%0d", t, o.n_read, o.n_write, e_nr, e_nw); end
            if (e_nr + e_nw > 0) begin
                n_chk++; if ({o.maddr, o.msize, o.msigned} !== {a_addr, e_sz, e_sg}) begin n_err++; $display("FAIL rnd_mem_ctrl[%0d] got=%h exp=%h", t, {o.maddr, o.msize, o.msigned}, {a_addr, e_sz, e_sg}); end
            end
            if (e_nw > 0) begin
                n_chk++; if (o.mwdata !== a_wd || o.first_wr !== 1) begin n_err++; $display("FAIL rnd_wdata[%0d] got=%h@%0d exp=%h@1", t, o.mwdata, o.first_wr, a_wd); end
                ref_store(a_addr, e_sz, a_wd);
            end
            n_chk++; if ({o.busy_gnt, o.busy_low, o.resp_nz, o.idle_busy} !== 4'b0000) begin n_err++; $display("FAIL rnd_misc[%0d] got=%b exp=0000", t, {o.busy_gnt, o.busy_low, o.resp_nz, o.idle_busy}); end
            if (!e_ls)        m_starve = 0;
            else if (a_ifreq) m_starve = (m_starve < SM) ? m_starve + 1 : SM;
            else              m_starve = 0;
        end
        @(posedge clk); #1;
        if_req = 1'b0; ls_req = 1'b0; m_starve = 0;
    endtask

    task automatic test_reset_mid_store();
        logic w = 1'b0, v = 1'b0, b = 1'b0, g;
        @(posedge clk); #1;
        set_ls(1'b1, 2'b00, 1'b0, 8'h10, 32'h1234_5678);
        @(negedge clk); g = ls_gnt;
        @(posedge clk); #1; ls_req = 1'b0;
        @(negedge clk);
        n_chk++; if ({g, mem_write} !== 2'b11) begin n_err++; $display("FAIL rst_store_start got=%b exp=11", {g, mem_write}); end
        ref_store(8'h10, 2'b00, 32'h1234_5678);
        @(posedge clk); #1; rst_n = 1'b0;
        @(negedge clk); w |= mem_write; v |= ls_valid | if_valid;
        @(posedge clk); #1; rst_n = 1'b1; m_starve = 0;
        repeat (6) begin
            @(negedge clk); w |= mem_write; v |= ls_valid | if_valid; b |= busy;
        end
        n_chk++; if (w !== 1'b0) begin n_err++; $display("FAIL rst_no_rewrite got=%b exp=0", w); end
        n_chk++; if (v !== 1'b0) begin n_err++; $display("FAIL rst_no_valid got=%b exp=0", v); end
        n_chk++; if (b !== 1'b0) begin n_err++; $display("FAIL rst_busy got=%b exp=0", b); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) preload(8'(i), 8'($urandom_range(0, 255)));
        test_reset();
        test_if_fetch();
        test_store_load();
        test_lh_signed();
        test_misaligned();
        test_starvation();
        test_random();
        test_reset_mid_store();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog timeout after %0d checks", n_chk);
        $fatal(1, "timeout");
    end

endmodule
